wrr_scheduler: RTL
==================

WRR_SCHEDULER -- requirements
Module: wrr_scheduler

Interface
REQ-001 Parameters SHALL be: NUM_Q 8 (number of priority queues); PRIORITY_BIT 3 (queue index width); WEIGHT_BIT 4 (per-queue weight width); TIMEOUT 1023 (maximum WAIT_DONE cycles).
REQ-002 Ports SHALL be, in this order:
- clk  in  1  sole clock.
- rst  in  1  reset; asynchronous, active-high.
- q_empty  in  NUM_Q  per-queue FIFO empty flags.
- weight_cfg  in  NUM_Q*WEIGHT_BIT  weights; queue i at bits [i*WEIGHT_BIT +: WEIGHT_BIT].
- cfg_load  in  1  one-cycle pulse that requests loading of weight_cfg.
- ready  in  1  downstream unpacker can accept a packet.
- pkt_done  in  1  one-cycle pulse from the unpacker at end of packet (eop).
- rd_en  out  NUM_Q  one-hot FIFO read strobe.
- grant_id  out  PRIORITY_BIT  index of the granted queue.
- grant_vld  out  1  grant active.
- busy  out  1  state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a grant is aborted.

Function
REQ-003 The block SHALL hold internal registers weight[i], credit[i] (each WEIGHT_BIT wide), ptr (PRIORITY_BIT wide), cfg_pend (1 bit) and wdog (10 bits).
REQ-004 Queue i SHALL be eligible when q_empty[i]==0 and weight[i]!=0; a queue with weight 0 SHALL never be granted.
REQ-005 The FSM SHALL have the states IDLE, SELECT, READ and WAIT_DONE.
REQ-006 IDLE -> SELECT SHALL occur when ready==1 and at least one queue is eligible; otherwise the FSM SHALL stay in IDLE.
REQ-007 In SELECT, the scan SHALL find the first eligible queue with credit>0, starting at ptr inclusive and wrapping modulo NUM_Q.
REQ-008 On a SELECT hit, the block SHALL register grant_id, decrement credit[grant_id] by 1, and go to READ.
REQ-009 On a SELECT miss with at least one queue eligible, the block SHALL load credit[i]=weight[i] for all i, leave ptr unchanged, and stay in SELECT (one reload cycle).
REQ-010 On a SELECT miss with no queue eligible, the FSM SHALL go to IDLE.
REQ-011 In READ, rd_en SHALL equal 1<<grant_id for exactly one cycle, and the FSM SHALL then go to WAIT_DONE; in all other cycles rd_en SHALL be 0.
REQ-012 grant_vld SHALL be 1 in READ and WAIT_DONE and 0 otherwise; grant_id SHALL stay stable while grant_vld==1.
REQ-013 In WAIT_DONE, pkt_done==1 SHALL move the FSM to IDLE; pkt_done in any other state SHALL be ignored.
REQ-014 ptr update on leaving WAIT_DONE:
- if credit[grant_id]==0 or q_empty[grant_id]==1, ptr SHALL become grant_id+1 (mod NUM_Q);
- otherwise ptr SHALL be unchanged, so the same queue is served again.
REQ-015 wdog SHALL clear on entry to WAIT_DONE and increment each cycle in WAIT_DONE.
REQ-016 When wdog==TIMEOUT in WAIT_DONE, the block SHALL pulse timeout_err for 1 cycle, apply REQ-014 as if credit[grant_id]==0, and go to IDLE.
REQ-017 If pkt_done and the timeout occur in the same cycle, pkt_done SHALL win and timeout_err SHALL stay 0.
REQ-018 A cfg_load in IDLE SHALL copy weight_cfg into weight[], set credit[i]=weight_cfg[i], and block the IDLE -> SELECT transition that cycle.
REQ-019 A cfg_load in any other state SHALL set cfg_pend; the load SHALL be applied on the first IDLE cycle, after which cfg_pend SHALL clear.
REQ-020 While cfg_pend==1, the IDLE -> SELECT transition SHALL be suppressed.
REQ-021 ready SHALL be sampled only in IDLE; a drop of ready after IDLE SHALL not abort a grant.
REQ-022 busy SHALL be 1 whenever the state is not IDLE.
REQ-023 Worst-case latency from IDLE with an eligible queue to the rd_en pulse SHALL be 4 cycles (IDLE, SELECT, reload, SELECT hit -> READ); it SHALL be 3 cycles when no reload is needed.

Reset
REQ-024 While rst==1, regardless of clk: state SHALL be IDLE; rd_en=0, grant_id=0, grant_vld=0, busy=0, timeout_err=0; ptr=0, cfg_pend=0, wdog=0; weight[i]=1 and credit[i]=1 for all i.
REQ-025 Reset asserted mid-grant SHALL drop rd_en and grant_vld immediately (asynchronously), with no further strobes.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Weights {q0=3, q1=1}, both queues always non-empty, pkt_done 2 cycles after each rd_en -> grant sequence 0,0,0,1,0,0,0,1.
- Weights all 1, queues 2, 5 and 7 non-empty -> grants 2,5,7,2 with one reload cycle before the second 2.
- q3 weight 0 and non-empty, all other queues empty -> grant_vld never rises and busy stays 0.
- Grant on q4, pkt_done withheld -> timeout_err pulses at WAIT_DONE cycle 1023, then ptr==5.
- cfg_load pulse during WAIT_DONE -> no new grant until the IDLE cycle in which the new weights load, with credits equal to the new weights.
- rst asserted in the READ cycle -> rd_en==0 in the same cycle and all outputs at reset values.

Source files
------------

// File: rtl/wrr_scheduler.sv
// Weighted round-robin scheduler over NUM_Q FIFOs.
// Each grant reads one packet from the chosen FIFO and waits for the unpacker's
// end-of-packet before scheduling again. Credits are refilled from the weights
// only when no eligible queue has credit left. A watchdog aborts stuck grants.
module wrr_scheduler #(
    parameter int NUM_Q        = 8,
    parameter int PRIORITY_BIT = 3,
    parameter int WEIGHT_BIT   = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_Q-1:0]            q_empty,
    input  logic [NUM_Q*WEIGHT_BIT-1:0] weight_cfg,
    input  logic                        cfg_load,
    input  logic                        ready,
    input  logic                        pkt_done,
    output logic [NUM_Q-1:0]            rd_en,
    output logic [PRIORITY_BIT-1:0]     grant_id,
    output logic                        grant_vld,
    output logic                        busy,
    output logic                        timeout_err
);
    localparam int WDOG_BIT = 10;

    typedef enum logic [1:0] {IDLE, SELECT, READ, WAIT_DONE} state_e;

    state_e                           state_q, state_d;
    logic [NUM_Q-1:0][WEIGHT_BIT-1:0] weight_q, weight_d;
    logic [NUM_Q-1:0][WEIGHT_BIT-1:0] credit_q, credit_d;
    logic [PRIORITY_BIT-1:0]          ptr_q, ptr_d;
    logic [PRIORITY_BIT-1:0]          gid_q, gid_d;
    logic                             cfg_pend_q, cfg_pend_d;
    logic [WDOG_BIT-1:0]              wdog_q, wdog_d;

    logic [NUM_Q-1:0]        elig;
    logic [NUM_Q-1:0]        cand;
    logic                    any_elig;
    logic                    hit;
    logic [PRIORITY_BIT-1:0] hit_id;
    logic [PRIORITY_BIT-1:0] gid_inc;
    logic                    load_now;
    logic                    tmo;

    // Eligibility (non-empty with non-zero weight) and candidates that still hold credit
    always_comb begin
        for (int i = 0; i < NUM_Q; i++) begin
            elig[i] = !q_empty[i] && (weight_q[i] != '0);
            cand[i] = elig[i] && (credit_q[i] != '0);
        end
        any_elig = |elig;
        gid_inc  = PRIORITY_BIT'((int'(gid_q) + 1) % NUM_Q);
        // A pending load is applied in the first IDLE cycle, same as a direct one
        load_now = (state_q == IDLE) && (cfg_load || cfg_pend_q);
        // pkt_done in the expiry cycle takes precedence over the abort
        tmo      = (state_q == WAIT_DONE) && !pkt_done && (wdog_q == WDOG_BIT'(TIMEOUT));
    end

    // Circular scan for the first candidate, starting at ptr inclusive
    always_comb begin
        int j;
        j      = 0;
        hit    = 1'b0;
        hit_id = ptr_q;
        for (int k = 0; k < NUM_Q; k++) begin
            j = (int'(ptr_q) + k) % NUM_Q;
            if (!hit && cand[j]) begin
                hit    = 1'b1;
                hit_id = PRIORITY_BIT'(j);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic; ready is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (!load_now && ready && any_elig) state_d = SELECT;
            SELECT:    if (hit) state_d = READ;
                       else if (!any_elig) state_d = IDLE;
            READ:      state_d = WAIT_DONE;
            WAIT_DONE: if (pkt_done || tmo) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // FSM outputs: all decoded from state so reset clears them immediately
    always_comb begin
        rd_en = '0;
        if (state_q == READ) rd_en[gid_q] = 1'b1;
        grant_vld   = (state_q == READ) || (state_q == WAIT_DONE);
        busy        = (state_q != IDLE);
        timeout_err = tmo;
        grant_id    = gid_q;
    end

    // Datapath next values: config load, credit spend/refill, pointer and watchdog
    always_comb begin
        weight_d   = weight_q;
        credit_d   = credit_q;
        ptr_d      = ptr_q;
        gid_d      = gid_q;
        wdog_d     = wdog_q;
        cfg_pend_d = cfg_pend_q;
        if (load_now) begin
            weight_d   = weight_cfg;
            credit_d   = weight_cfg;
            cfg_pend_d = 1'b0;
        end else if (cfg_load) begin
            cfg_pend_d = 1'b1;
        end
        unique case (state_q)
            SELECT: begin
                if (hit) begin
                    gid_d            = hit_id;
                    credit_d[hit_id] = credit_q[hit_id] - WEIGHT_BIT'(1);
                end else if (any_elig) begin
                    // Every eligible queue is out of credit: refill, ptr kept
                    credit_d = weight_q;
                end
            end
            READ: wdog_d = '0;
            WAIT_DONE: begin
                if (pkt_done) begin
                    // Stay on this queue while it has credit and data
                    if (credit_q[gid_q] == '0 || q_empty[gid_q]) ptr_d = gid_inc;
                end else if (tmo) begin
                    ptr_d = gid_inc;
                end else begin
                    wdog_d = wdog_q + WDOG_BIT'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_q   <= {NUM_Q{WEIGHT_BIT'(1)}};
            credit_q   <= {NUM_Q{WEIGHT_BIT'(1)}};
            ptr_q      <= '0;
            gid_q      <= '0;
            wdog_q     <= '0;
            cfg_pend_q <= 1'b0;
        end else begin
            weight_q   <= weight_d;
            credit_q   <= credit_d;
            ptr_q      <= ptr_d;
            gid_q      <= gid_d;
            wdog_q     <= wdog_d;
            cfg_pend_q <= cfg_pend_d;
        end
    end

endmodule
